from_polar: RTL and testbench
=============================

// Module: from_polar
// PURPOSE
//  Polar-to-rectangular converter: fully pipelined rotation-mode CORDIC. Takes
//  magnitude + phase, returns gain-compensated signed x/y. Reverse of topolar;
//  sits on the same i_ce-strobed sample stream. i_aux travels alongside each
//  sample for valid/frame tagging.
// PARAMETERS
//  IW       12  unsigned magnitude input width
//  PW       19  phase width; 2^PW = one full turn
//  OW       13  signed x/y output width (IW+1, covers |mag*cos| = 2^IW-1)
//  NSTAGES  16  CORDIC micro-rotation stages
//  WW       18  internal x/y working width (IW+6: guard and growth bits)
// PORTS
//  i_clk     in   1   clock; all logic on rising edge
//  i_reset   in   1   synchronous, active-high reset
//  i_ce      in   1   clock enable; pipeline advances only when high
//  i_mag     in   IW  magnitude, unsigned
//  i_phase   in   PW  phase, unsigned; 0 = 0 rad, 2^(PW-2) = +90 deg, wraps mod 2^PW
//  i_aux     in   1   sideband bit, delayed to match the data
//  o_xval    out  OW  mag*cos(phase), signed two's complement
//  o_yval    out  OW  mag*sin(phase), signed two's complement
//  o_aux     out  1   i_aux delayed by LATENCY enabled cycles
// BEHAVIOUR
//  - Reset: i_reset high at a clock edge clears every pipeline register, o_xval,
//    o_yval and o_aux to 0, regardless of i_ce. Reset mid-stream discards all
//    in-flight samples. First valid output comes LATENCY enabled cycles after
//    the first post-reset enabled input.
//  - i_ce low: every register holds, outputs included. No bubbles, no skid.
//  - LATENCY = NSTAGES+3 enabled cycles: S0 pre-rotate, S1..S_NSTAGES
//    micro-rotations, gain multiply, round/saturate register.
//  - S0 pre-rotate: x0 = i_mag<<(WW-IW-2), y0 = 0, z0 = i_phase.
//    If phase[PW-1:PW-2] is 01 or 10 (90..270 deg), x0 = -x0 and
//    z0 = i_phase - 2^(PW-1). Residual z is then in [-90,+90) deg, signed PW bits.
//  - Stage k (k = 0..NSTAGES-1): d = (z>=0). If d:
//    x -= y>>>k, y += x>>>k, z -= A[k]; else the opposite signs.
//    Shifts are arithmetic and all use previous-stage values.
//  - A[k] = round(atan(2^-k) * 2^PW / (2*pi)), a constant table.
//    For PW=19: A[0]=65536, A[1]=38688, A[2]=20442, ...
//  - Gain compensation: x,y each multiplied by the constant
//    KINV = round(2^16/1.646760) = 39797 (Q0.16). The product is kept at full
//    width, then >>16.
//  - Output stage: drop the WW-IW-2 fraction bits with round-half-up
//    (add 1/2 LSB, then truncate). Saturate to [-(2^(OW-1)-1), +(2^(OW-1)-1)].
//    -2^(OW-1) is never emitted.
//  - Accuracy: |error| <= 2 LSB on each output for all inputs with i_mag>0.
//    i_mag=0 gives exactly 0,0.
//  - i_aux is never combined with data. It is a pure LATENCY-deep shift register
//    on i_ce.
//  - Phase wrap: i_phase = 2^PW-1 is treated as just below 0 deg, not near 360
//    with a jump. The pre-rotate quadrant test handles all four quadrant edges:
//    0, 2^(PW-2), 2^(PW-1), 3*2^(PW-2).
// TESTING
//  1. Reset: hold i_reset 4 cycles with i_ce=1 and random inputs
//     -> o_xval=o_yval=0 and o_aux=0 throughout and 1 cycle after release.
//  2. mag=1000 at phase 0 / 131072 / 262144 / 393216
//     -> (x,y) = (1000,0) / (0,1000) / (-1000,0) / (0,-1000), each +/-2.
//  3. mag=4095, phase=65536 (45 deg) -> x=y=2896 +/-2.
//     mag=4095, phase=0 -> x=4095, no wrap; saturation not exceeded.
//  4. Latency/aux: one i_aux=1 pulse with i_ce always high
//     -> o_aux=1 exactly NSTAGES+3=19 cycles later, aligned with that sample.
//  5. Stall: random i_ce at 50% density, random mag/phase stream
//     -> output sequence identical to the i_ce=1 run. Outputs stable while i_ce=0.
//  6. Mid-stream reset: 1-cycle i_reset after 10 samples
//     -> no pre-reset sample ever appears on the outputs. The first new sample
//     emerges 19 enabled cycles after the first post-reset input.

Source files
------------

// File: rtl/from_polar.sv
// Polar-to-rectangular converter: pipelined rotation-mode CORDIC with quadrant
// pre-rotation, constant gain compensation and a rounding/saturating output stage.
module from_polar #(
  parameter int IW      = 12,
  parameter int PW      = 19,
  parameter int OW      = 13,
  parameter int NSTAGES = 16,
  parameter int WW      = 18
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [IW-1:0]        i_mag,
  input  logic [PW-1:0]        i_phase,
  input  logic                 i_aux,
  output logic signed [OW-1:0] o_xval,
  output logic signed [OW-1:0] o_yval,
  output logic                 o_aux
);

  localparam int FRAC    = WW - IW - 2;
  localparam int GW      = WW + 2;
  localparam int RW      = GW + 1 - FRAC;
  localparam int LATENCY = NSTAGES + 3;

  localparam logic signed [17:0]   KINV   = 18'sd39797;
  localparam logic signed [RW-1:0] OMAX_R = RW'((2 ** (OW - 1)) - 1);
  localparam logic signed [OW-1:0] OMAX_O = OW'((2 ** (OW - 1)) - 1);

  // atan(2^-k) in units of 2^-PW turns, for PW = 19
  function automatic logic signed [PW-1:0] atan_step(input int k);
    int a;
    case (k)
      0:       a = 65536;
      1:       a = 38688;
      2:       a = 20442;
      3:       a = 10377;
      4:       a = 5208;
      5:       a = 2607;
      6:       a = 1304;
      7:       a = 652;
      8:       a = 326;
      9:       a = 163;
      10:      a = 81;
      11:      a = 41;
      12:      a = 20;
      13:      a = 10;
      14:      a = 5;
      15:      a = 3;
      default: a = 0;
    endcase
    return PW'(a);
  endfunction

  logic signed [WW-1:0] x_q [NSTAGES+1];
  logic signed [WW-1:0] x_d [NSTAGES+1];
  logic signed [WW-1:0] y_q [NSTAGES+1];
  logic signed [WW-1:0] y_d [NSTAGES+1];
  logic signed [PW-1:0] z_q [NSTAGES+1];
  logic signed [PW-1:0] z_d [NSTAGES+1];

  logic signed [WW-1:0]    x_pre;
  logic signed [WW+17:0]   px;
  logic signed [WW+17:0]   py;
  logic signed [GW-1:0]    gx_q, gx_d;
  logic signed [GW-1:0]    gy_q, gy_d;
  logic signed [GW:0]      rx;
  logic signed [GW:0]      ry;
  logic signed [RW-1:0]    sx;
  logic signed [RW-1:0]    sy;
  logic signed [OW-1:0]    ox_q, ox_d;
  logic signed [OW-1:0]    oy_q, oy_d;
  logic [LATENCY-1:0]      aux_q, aux_d;
  logic                    unused_bits;

  // Pre-rotation folds quadrants 1 and 2 onto the right half-plane by a 180 deg turn
  always_comb begin
    x_pre = WW'(i_mag) << FRAC;
    y_d[0] = '0;
    if (i_phase[PW-1] ^ i_phase[PW-2]) begin
      x_d[0] = -x_pre;
      z_d[0] = {~i_phase[PW-1], i_phase[PW-2:0]};
    end else begin
      x_d[0] = x_pre;
      z_d[0] = i_phase;
    end

    for (int k = 0; k < NSTAGES; k++) begin
      if (!z_q[k][PW-1]) begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        y_d[k+1] = y_q[k] + (x_q[k] >>> k);
        z_d[k+1] = z_q[k] - atan_step(k);
      end else begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        y_d[k+1] = y_q[k] - (x_q[k] >>> k);
        z_d[k+1] = z_q[k] + atan_step(k);
      end
    end
  end

  always_comb begin
    px   = (WW+18)'(x_q[NSTAGES]) * (WW+18)'(KINV);
    py   = (WW+18)'(y_q[NSTAGES]) * (WW+18)'(KINV);
    gx_d = px[WW+17:16];
    gy_d = py[WW+17:16];

    // round half-up: add half an output LSB, then drop the guard bits
    rx = {gx_q[GW-1], gx_q} + (GW+1)'(2 ** (FRAC - 1));
    ry = {gy_q[GW-1], gy_q} + (GW+1)'(2 ** (FRAC - 1));
    sx = rx[GW:FRAC];
    sy = ry[GW:FRAC];

    if (sx > OMAX_R)       ox_d = OMAX_O;
    else if (sx < -OMAX_R) ox_d = -OMAX_O;
    else                   ox_d = sx[OW-1:0];

    if (sy > OMAX_R)       oy_d = OMAX_O;
    else if (sy < -OMAX_R) oy_d = -OMAX_O;
    else                   oy_d = sy[OW-1:0];

    aux_d = {aux_q[LATENCY-2:0], i_aux};

    unused_bits = ^{px[15:0], py[15:0], rx[FRAC-1:0], ry[FRAC-1:0], z_q[NSTAGES]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k <= NSTAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
      gx_q  <= '0;
      gy_q  <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      aux_q <= '0;
    end else if (i_ce) begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      aux_q <= aux_d;
    end
  end

  assign o_xval = ox_q;
  assign o_yval = oy_q;
  assign o_aux  = aux_q[LATENCY-1];

endmodule

// File: tb/tb_from_polar.sv
// Self-checking bench for from_polar: directed vector table, random stream with
// random clock-enable, reset sequences, checked against an ideal trig model.
module tb_from_polar;
  localparam int IW   = 12;
  localparam int PW   = 19;
  localparam int OW   = 13;
  localparam int LAT  = 19;
  localparam int OMAX = 4095;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_ce = 1'b0;
  logic [IW-1:0]        i_mag = '0;
  logic [PW-1:0]        i_phase = '0;
  logic                 i_aux = 1'b0;
  logic signed [OW-1:0] o_xval;
  logic signed [OW-1:0] o_yval;
  logic                 o_aux;

  from_polar dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_mag   (i_mag),
    .i_phase (i_phase),
    .i_aux   (i_aux),
    .o_xval  (o_xval),
    .o_yval  (o_yval),
    .o_aux   (o_aux)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int tol;
    bit aux;
  } exp_t;

  typedef struct {
    int mag;
    int phase;
    bit aux;
    int ex;
    int ey;
    int tol;
  } vec_t;

  exp_t mq[$];
  exp_t cur;
  vec_t vecs[16];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int ideal_round(real v);
    int r;
    r = $rtoi($floor(v + 0.5));
    if (r > OMAX) r = OMAX;
    if (r < -OMAX) r = -OMAX;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/-%0d at %0t", name, act, exp, tol, $time);
    end
  endtask

  // One clock: drive inputs, advance the latency model, check outputs after the edge
  task automatic step(input bit rst, input bit ce, input int mag, input int phase,
                      input bit aux, input int ex, input int ey, input int tol);
    int   prev_x, prev_y;
    exp_t e;
    prev_x  = o_xval;
    prev_y  = o_yval;
    i_reset = rst;
    i_ce    = ce;
    i_mag   = mag[IW-1:0];
    i_phase = phase[PW-1:0];
    i_aux   = aux;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      e.x = 0; e.y = 0; e.tol = 0; e.aux = 1'b0;
      for (int i = 0; i < LAT - 1; i++) mq.push_back(e);
      cur = e;
    end else if (ce) begin
      e.x = ex; e.y = ey; e.tol = tol; e.aux = aux;
      mq.push_back(e);
      cur = mq.pop_front();
    end
    check("xval", o_xval, cur.x, cur.tol);
    check("yval", o_yval, cur.y, cur.tol);
    check("aux", int'(o_aux), int'(cur.aux), 0);
    if (!rst && !ce) begin
      check("x_hold", o_xval, prev_x, 0);
      check("y_hold", o_yval, prev_y, 0);
    end
    n_vec++;
    if (o_xval == -(OMAX + 1) || o_yval == -(OMAX + 1)) begin
      n_err++;
      $display("FAIL neg_full_scale: got x=%0d y=%0d, want > %0d", o_xval, o_yval, -(OMAX + 1));
    end
  endtask

  task automatic step_model(input bit rst, input bit ce, input int mag, input int phase, input bit aux);
    real ang;
    int  ex, ey;
    ang = 2.0 * 3.141592653589793 * real'(phase) / 524288.0;
    ex  = ideal_round(real'(mag) * $cos(ang));
    ey  = ideal_round(real'(mag) * $sin(ang));
    step(rst, ce, mag, phase, aux, ex, ey, (mag == 0) ? 0 : 2);
  endtask

  task automatic step_rand(input bit rst, input bit ce);
    step_model(rst, ce, int'($urandom_range(4095)), int'($urandom_range(524287)), bit'($urandom % 2));
  endtask

  initial begin
    int cnt;
    bit seen;

    vecs[0]  = '{1000, 0,      1'b1, 1000,  0,     2};
    vecs[1]  = '{1000, 131072, 1'b0, 0,     1000,  2};
    vecs[2]  = '{1000, 262144, 1'b1, -1000, 0,     2};
    vecs[3]  = '{1000, 393216, 1'b0, 0,     -1000, 2};
    vecs[4]  = '{4095, 65536,  1'b1, 2896,  2896,  2};
    vecs[5]  = '{4095, 0,      1'b0, 4095,  0,     2};
    vecs[6]  = '{0,    12345,  1'b1, 0,     0,     0};
    vecs[7]  = '{0,    393216, 1'b0, 0,     0,     0};
    vecs[8]  = '{4095, 524287, 1'b1, 4095,  0,     2};
    vecs[9]  = '{4095, 262144, 1'b0, -4095, 0,     2};
    vecs[10] = '{4095, 131071, 1'b1, 0,     4095,  2};
    vecs[11] = '{4095, 131072, 1'b0, 0,     4095,  2};
    vecs[12] = '{4095, 262143, 1'b1, -4095, 0,     2};
    vecs[13] = '{4095, 393215, 1'b0, 0,     -4095, 2};
    vecs[14] = '{2048, 196608, 1'b1, -1448, 1448,  2};
    vecs[15] = '{1,    0,      1'b0, 1,     0,     2};

    // reset held with enable high and live inputs, then one cycle after release
    repeat (4) step_rand(1'b1, 1'b1);
    step_rand(1'b0, 1'b1);

    foreach (vecs[i])
      step(1'b0, 1'b1, vecs[i].mag, vecs[i].phase, vecs[i].aux, vecs[i].ex, vecs[i].ey, vecs[i].tol);
    repeat (LAT) step_rand(1'b0, 1'b1);

    // single aux pulse must surface exactly LAT enabled cycles after entry
    step_model(1'b1, 1'b1, 0, 0, 1'b0);
    step_model(1'b0, 1'b1, 1000, 0, 1'b1);
    cnt  = 1;
    seen = o_aux;
    while (!seen && cnt < 3 * LAT) begin
      step_model(1'b0, 1'b1, 1000, 0, 1'b0);
      cnt++;
      seen = o_aux;
    end
    n_vec++;
    if (!seen || cnt != LAT) begin
      n_err++;
      $display("FAIL aux_latency: got seen=%0d after %0d cycles, want %0d", seen, cnt, LAT);
    end

    // random stream with roughly half-density clock enable
    repeat (800) step_rand(1'b0, bit'($urandom % 2));
    repeat (LAT) step_rand(1'b0, 1'b1);

    // mid-stream reset: nothing from before the pulse may reach the outputs
    repeat (10) step_model(1'b0, 1'b1, int'($urandom_range(1, 4095)), int'($urandom_range(524287)), 1'b1);
    step_rand(1'b1, 1'b1);
    step_model(1'b0, 1'b1, 3000, 0, 1'b1);
    repeat (30) step_rand(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
